// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencer for a repeated-addition multiplier datapath.
// Captures A and B from the shared bus and drives the A-register load and the
// product-register clear/load strobes. B is kept in a down-counter, and one
// add strobe is issued for each unit of B.
module mul_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [W-1:0] din,
    output logic         ldA,
    output logic         clrP,
    output logic         ldP,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ADD    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state;

    // Moore output decode. It returns {ldA, clrP, ldP, busy, done} for the
    // state being entered. The outputs are registered together with the state,
    // so they always match the current state and never see din or start.
    function automatic logic [4:0] decode(input state_t s);
        logic [4:0] o;
        o = 5'b00000;
        case (s)
            IDLE:    o = 5'b00000;
            LOAD_A:  o = 5'b10010;
            LOAD_B:  o = 5'b01010;
            ADD:     o = 5'b00110;
            DONE:    o = 5'b00011;
            default: o = 5'b00000;
        endcase
        return o;
    endfunction

    // Single-process FSM: state, counter and registered strobes.
    // The counter is only written in LOAD_B and ADD, so it holds elsewhere.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            ldA   <= 1'b0;
            clrP  <= 1'b0;
            ldP   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_A;
                        {ldA, clrP, ldP, busy, done} <= decode(LOAD_A);
                    end else begin
                        state <= IDLE;
                        {ldA, clrP, ldP, busy, done} <= decode(IDLE);
                    end
                end
                LOAD_A: begin
                    state <= LOAD_B;
                    {ldA, clrP, ldP, busy, done} <= decode(LOAD_B);
                end
                LOAD_B: begin
                    cnt <= din;
                    if (din == '0) begin
                        state <= DONE;
                        {ldA, clrP, ldP, busy, done} <= decode(DONE);
                    end else begin
                        state <= ADD;
                        {ldA, clrP, ldP, busy, done} <= decode(ADD);
                    end
                end
                ADD: begin
                    // Guard against underflow. An ADD state with cnt==0 is
                    // unreachable in normal operation, but it exits cleanly.
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                    if (cnt <= {{(W-1){1'b0}}, 1'b1}) begin
                        state <= DONE;
                        {ldA, clrP, ldP, busy, done} <= decode(DONE);
                    end else begin
                        state <= ADD;
                        {ldA, clrP, ldP, busy, done} <= decode(ADD);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    {ldA, clrP, ldP, busy, done} <= decode(IDLE);
                end
                default: begin
                    state <= IDLE;
                    {ldA, clrP, ldP, busy, done} <= decode(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl. It uses a 16-bit instance and a 4-bit instance,
// each paired with a small A-register / product-register datapath model.
module tb_mul_ctrl;

    logic        clk;
    logic        clr, start;
    logic [15:0] din;
    logic        ldA, clrP, ldP, busy, done;
    logic [15:0] cnt;

    logic        clr4, start4;
    logic [3:0]  din4;
    logic        ldA4, clrP4, ldP4, busy4, done4;
    logic [3:0]  cnt4;

    logic [15:0] a_r, p_r;
    logic [3:0]  a4_r, p4_r;

    int total = 0;
    int bad   = 0;

    mul_ctrl #(.W(16)) u_dut (
        .clk(clk), .clr(clr), .start(start), .din(din),
        .ldA(ldA), .clrP(clrP), .ldP(ldP), .busy(busy), .done(done), .cnt(cnt)
    );

    mul_ctrl #(.W(4)) u_dut4 (
        .clk(clk), .clr(clr4), .start(start4), .din(din4),
        .ldA(ldA4), .clrP(clrP4), .ldP(ldP4), .busy(busy4), .done(done4), .cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath models driven by the controller strobes.
    always_ff @(posedge clk) begin
        if (ldA) a_r <= din;
        if (clrP) p_r <= '0;
        else if (ldP) p_r <= p_r + a_r;
        if (ldA4) a4_r <= din4;
        if (clrP4) p4_r <= '0;
        else if (ldP4) p4_r <= p4_r + a4_r;
    end

    function automatic logic [4:0] outs();
        return {ldA, clrP, ldP, busy, done};
    endfunction

    function automatic logic [4:0] outs4();
        return {ldA4, clrP4, ldP4, busy4, done4};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation on the 16-bit instance.
    // mode 0: start pulse; mode 1: start left high afterwards;
    // mode 2: start driven high during LOAD_B, ADD and DONE.
    task automatic op(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] prod, input int mode, input string tag);
        start = 1'b1;
        step();
        if (mode != 1) start = 1'b0;
        chk({tag, "_loadA"}, 32'(outs()), 32'b10010);
        din = a;
        step();
        chk({tag, "_loadB"}, 32'(outs()), 32'b01010);
        if (mode == 2) start = 1'b1;
        din = b;
        step();
        for (int i = 0; i < int'(b); i++) begin
            chk({tag, "_add"}, 32'(outs()), 32'b00110);
            chk({tag, "_addcnt"}, 32'(cnt), 32'(b) - 32'(i));
            step();
        end
        chk({tag, "_done"}, 32'(outs()), 32'b00011);
        chk({tag, "_donecnt"}, 32'(cnt), 32'd0);
        chk({tag, "_prod"}, 32'(p_r), 32'(prod));
        step();
        if (mode == 2) start = 1'b0;
        chk({tag, "_idle"}, 32'(outs()), 32'b00000);
        chk({tag, "_idlecnt"}, 32'(cnt), 32'd0);
        if (mode == 2) begin
            step();
            chk({tag, "_stillidle"}, 32'(outs()), 32'b00000);
        end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; din = '0;
        clr4 = 1'b1; start4 = 1'b0; din4 = '0;
        #2;
        chk("rst_outs", 32'(outs()), 32'b00000);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_outs4", 32'(outs4()), 32'b00000);
        step();
        clr = 1'b0; clr4 = 1'b0;
        step();
        chk("idle_nostart", 32'(outs()), 32'b00000);

        // A=5, B=3 -> 15
        op(16'd5, 16'd3, 16'd15, 0, "op5x3");
        // A=7, B=0 -> 0, no add cycles
        op(16'd7, 16'd0, 16'd0, 0, "op7x0");
        // Back-to-back with start held high: 2*2=4 then 3*1=3
        op(16'd2, 16'd2, 16'd4, 1, "b2b_first");
        op(16'd3, 16'd1, 16'd3, 0, "b2b_second");

        // Asynchronous clear in the middle of ADD (A=4, B=10, after 3 adds)
        start = 1'b1;
        step();
        start = 1'b0;
        din = 16'd4;
        step();
        din = 16'd10;
        step();
        step();
        step();
        step();
        chk("mid_add", 32'(outs()), 32'b00110);
        chk("mid_cnt", 32'(cnt), 32'd7);
        clr = 1'b1;
        #1;
        chk("aclr_outs", 32'(outs()), 32'b00000);
        chk("aclr_cnt", 32'(cnt), 32'd0);
        #1;
        clr = 1'b0;
        step();
        chk("after_clr_idle", 32'(outs()), 32'b00000);
        op(16'd1, 16'd2, 16'd2, 0, "post_clr");

        // Start pulses while busy are ignored
        op(16'd6, 16'd3, 16'd18, 2, "noise");

        // 4-bit instance: A=1, B=15 -> 15 adds, done at k+18, product 15
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        chk("w4_loadA", 32'(outs4()), 32'b10010);
        din4 = 4'd1;
        step();
        chk("w4_loadB", 32'(outs4()), 32'b01010);
        din4 = 4'd15;
        step();
        for (int i = 0; i < 15; i++) begin
            chk("w4_add", 32'(outs4()), 32'b00110);
            chk("w4_addcnt", 32'(cnt4), 32'd15 - 32'(i));
            step();
        end
        chk("w4_done", 32'(outs4()), 32'b00011);
        chk("w4_donecnt", 32'(cnt4), 32'd0);
        chk("w4_prod", 32'(p4_r), 32'd15);
        step();
        chk("w4_idle", 32'(outs4()), 32'b00000);
        chk("w4_nowrap", 32'(cnt4), 32'd0);
        step();
        chk("w4_nowrap2", 32'(cnt4), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
